issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Hazard scoreboard between decode and execute. Tracks integer registers with an outstanding write from a long-latency operation (load, mul/div, CSR read). Stalls issue on RAW or WAW hazards against those registers, on a busy mul/div unit, and when the in-flight count is full. Single-cycle ALU results are not tracked; they are covered by forwarding.

## Interface
- MAX_INFLIGHT, 4: maximum number of tracked long-latency writes outstanding (1..15).
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset rstn, synchronous, active-low; clock clk.
- issue_valid  in  1  decode holds a decoded instruction.
- issue_rs1  in  5  source 1 address; 0 means unused.
- issue_rs2  in  5  source 2 address; 0 means unused.
- issue_rd  in  5  destination address; 0 means no write.
- issue_long  in  1  instruction is long-latency (is_load, is_csr, mul..remu).
- issue_muldiv  in  1  instruction uses the mul/div unit.
- flush  in  1  branch/trap redirect; suppresses issue this cycle.
- wb_valid  in  1  long-latency writeback completes.
- wb_rd  in  5  register being written back.
- muldiv_done  in  1  mul/div unit finished (pulse).
- stall  out  1  hold decode/fetch this cycle.
- issue_fire  out  1  instruction leaves decode this cycle.
- busy_vec  out  32  per-register busy bits; bit 0 is always 0.
- inflight  out  4  count of tracked outstanding writes.
- err_spurious_wb  out  1  sticky; set by a writeback to a non-busy register or x0.

## Operation
- Hazard: raw = (rs1≠0 ∧ busy[rs1]) ∨ (rs2≠0 ∧ busy[rs2]); waw = rd≠0 ∧ busy[rd].
- Structural: struct = (issue_muldiv ∧ muldiv_busy) ∨ (issue_long ∧ rd≠0 ∧ inflight==MAX_INFLIGHT).
- stall = issue_valid ∧ (raw ∨ waw ∨ struct). Flush does not assert stall.
- issue_fire = issue_valid ∧ ¬stall ∧ ¬flush.
- On issue_fire ∧ issue_long ∧ rd≠0: set busy[rd] and increment inflight.
- On issue_fire ∧ issue_muldiv: set muldiv_busy.
- On wb_valid with wb_rd≠0 ∧ busy[wb_rd]: clear busy[wb_rd] and decrement inflight.
- On wb_valid with wb_rd==0 or ¬busy[wb_rd]: set err_spurious_wb. No counter change; no underflow.
- On muldiv_done: clear muldiv_busy.
- Same-cycle set and clear:
  - Different registers: both apply, and inflight is unchanged.
  - Same register: not possible, because WAW stalls the issue. With the bypass macro, the set wins and inflight is unchanged.
- Simultaneous muldiv_done and a muldiv issue: muldiv_busy stays 1.
- flush never clears busy bits; already-issued operations still write back.
- Reset values: busy_vec=0, inflight=0, muldiv_busy=0, err_spurious_wb=0, stall=0, issue_fire=0.
- Reset mid-operation clears all state; later writebacks to those registers flag err_spurious_wb.

## Timing
- stall and issue_fire are combinational from the current state and the inputs. There is no registered output path.
- An issue at edge N sets busy at N+1, so a dependent instruction in the following cycle stalls.
- Writeback at cycle N clears the bit at edge N+1. Without the bypass macro, the dependent instruction fires in cycle N+1 (one bubble).
- Pipeline-stage enable for decode = ¬stall.

## Configuration
- SCOREBOARD_WB_BYPASS_EN defined:
  - A register with wb_valid ∧ wb_rd==r in the current cycle is treated as not busy for the raw/waw checks.
  - The dependent instruction fires in the writeback cycle itself.
  - The inflight-full check also credits the same-cycle writeback.
- Undefined: hazard checks use the registered busy bits only.

## Structure
- In def.sv (shared header):
  - NUM_XREGS = 32.
  - Typedef scoreboard_t {busy[31:0], inflight, muldiv_busy}.
  - Long-latency classification helper constant list.
- Sub-module: hazard_check. Combinational raw/waw/struct evaluation taking the effective busy vector; reused by a future dual-issue path.
- Top module holds the registers, counter and error flag.

## Test plan
- Load to x5 issued, then `add x6,x5,x1` next cycle:
  - stall=1 until wb_valid/wb_rd=5.
  - issue_fire in the cycle after the writeback, or in the same cycle with SCOREBOARD_WB_BYPASS_EN.
- Four loads to x1..x4 with no writebacks, MAX_INFLIGHT=4:
  - inflight=4.
  - A fifth load to x7 stalls.
  - A concurrent ALU op to x8 with no hazard fires.
- `mul x3` issued, then `div x4`: stall until the muldiv_done pulse. Same-cycle done plus new mul issue → muldiv_busy remains 1.
- wb_valid with wb_rd=9 when busy[9]=0: err_spurious_wb=1 and stays set; inflight unchanged.
- flush=1 with issue_valid=1 and no hazard: issue_fire=0, stall=0, busy_vec unchanged.
- rstn=0 for one cycle with busy_vec=0x0000_0030 and inflight=2: next cycle busy_vec=0, inflight=0, err_spurious_wb=0.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
//------------------------------------------------------------------------------
// issue_scoreboard_pkg : shared types and constants for the issue scoreboard
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package issue_scoreboard_pkg;

    localparam int unsigned NUM_XREGS  = 32;
    localparam int unsigned INFLIGHT_W = 4;

    typedef struct packed {
        logic [NUM_XREGS-1:0]  busy;
        logic [INFLIGHT_W-1:0] inflight;
        logic                  muldiv_busy;
    } scoreboard_t;

    // Decoder op classes; only the long-latency ones get a busy bit.
    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_CSR    = 3'd2,
        OP_MULDIV = 3'd3,
        OP_BRANCH = 3'd4,
        OP_STORE  = 3'd5
    } op_class_t;

    function automatic logic is_long_op(input op_class_t op);
        return (op == OP_LOAD) || (op == OP_CSR) || (op == OP_MULDIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_scoreboard_if.sv
//------------------------------------------------------------------------------
// issue_scoreboard_if : decode/writeback handshake bundle for the scoreboard
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface issue_scoreboard_if;
    import issue_scoreboard_pkg::*;

    logic                  issue_valid;
    logic [4:0]            issue_rs1;
    logic [4:0]            issue_rs2;
    logic [4:0]            issue_rd;
    logic                  issue_long;
    logic                  issue_muldiv;
    logic                  flush;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic                  muldiv_done;
    logic                  stall;
    logic                  issue_fire;
    logic [NUM_XREGS-1:0]  busy_vec;
    logic [INFLIGHT_W-1:0] inflight;
    logic                  err_spurious_wb;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
               issue_muldiv, flush, wb_valid, wb_rd, muldiv_done,
        input  stall, issue_fire, busy_vec, inflight, err_spurious_wb
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_long,
               issue_muldiv, flush, wb_valid, wb_rd, muldiv_done,
        output stall, issue_fire, busy_vec, inflight, err_spurious_wb
    );

endinterface

`default_nettype wire

// File: rtl/issue_scoreboard_hazard_check.sv
//------------------------------------------------------------------------------
// issue_scoreboard_hazard_check : combinational RAW/WAW/structural evaluation
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module issue_scoreboard_hazard_check
    import issue_scoreboard_pkg::*;
(
    input  wire logic [NUM_XREGS-1:0] busy,
    input  wire logic [4:0]           rs1,
    input  wire logic [4:0]           rs2,
    input  wire logic [4:0]           rd,
    input  wire logic                 issue_long,
    input  wire logic                 issue_muldiv,
    input  wire logic                 muldiv_busy,
    input  wire logic                 inflight_full,
    output logic                      raw,
    output logic                      waw,
    output logic                      struct_haz
);

    assign raw = ((rs1 != 5'd0) && busy[rs1]) || ((rs2 != 5'd0) && busy[rs2]);
    assign waw = (rd != 5'd0) && busy[rd];
    // Only a tracked write (long op with a real destination) needs a free slot.
    assign struct_haz = (issue_muldiv && muldiv_busy)
                     || (issue_long && (rd != 5'd0) && inflight_full);

endmodule

`default_nettype wire

// File: rtl/issue_scoreboard.sv
//------------------------------------------------------------------------------
// issue_scoreboard : decode/execute hazard scoreboard for long-latency writes
// Optional macro: SCOREBOARD_WB_BYPASS_EN (same-cycle writeback clears hazard)
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    issue_scoreboard_if.slave sb
);

    scoreboard_t          state_q;
    scoreboard_t          state_d;
    logic                 err_q;
    logic                 wb_hit;
    logic [NUM_XREGS-1:0] wb_mask;
    logic [NUM_XREGS-1:0] set_mask;
    logic [NUM_XREGS-1:0] busy_eff;
    logic                 inflight_full;
    logic                 raw;
    logic                 waw;
    logic                 struct_haz;
    logic                 stall;
    logic                 fire;
    logic                 set_busy;

    assign wb_hit  = sb.wb_valid && (sb.wb_rd != 5'd0) && state_q.busy[sb.wb_rd];
    assign wb_mask = wb_hit ? (NUM_XREGS'(1) << sb.wb_rd) : '0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign busy_eff      = state_q.busy & ~wb_mask;
    assign inflight_full = (state_q.inflight == INFLIGHT_W'(MAX_INFLIGHT)) && !wb_hit;
`else
    assign busy_eff      = state_q.busy;
    assign inflight_full = (state_q.inflight == INFLIGHT_W'(MAX_INFLIGHT));
`endif

    issue_scoreboard_hazard_check u_hazard (
        .busy          (busy_eff),
        .rs1           (sb.issue_rs1),
        .rs2           (sb.issue_rs2),
        .rd            (sb.issue_rd),
        .issue_long    (sb.issue_long),
        .issue_muldiv  (sb.issue_muldiv),
        .muldiv_busy   (state_q.muldiv_busy),
        .inflight_full (inflight_full),
        .raw           (raw),
        .waw           (waw),
        .struct_haz    (struct_haz)
    );

    // Flush suppresses the issue but deliberately does not show up as a stall.
    assign stall    = sb.issue_valid && (raw || waw || struct_haz);
    assign fire     = sb.issue_valid && !stall && !sb.flush;
    assign set_busy = fire && sb.issue_long && (sb.issue_rd != 5'd0);
    assign set_mask = set_busy ? (NUM_XREGS'(1) << sb.issue_rd) : '0;

    always_comb begin
        state_d      = state_q;
        // Set applied after clear so a bypassed same-register pair stays busy.
        state_d.busy = (state_q.busy & ~wb_mask) | set_mask;
        case ({set_busy, wb_hit})
            2'b10:   state_d.inflight = state_q.inflight + INFLIGHT_W'(1);
            2'b01:   state_d.inflight = state_q.inflight - INFLIGHT_W'(1);
            default: state_d.inflight = state_q.inflight;
        endcase
        if (fire && sb.issue_muldiv) begin
            state_d.muldiv_busy = 1'b1;
        end else if (sb.muldiv_done) begin
            state_d.muldiv_busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sb.wb_valid && !wb_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign sb.stall           = stall;
    assign sb.issue_fire      = fire;
    assign sb.busy_vec        = state_q.busy;
    assign sb.inflight        = state_q.inflight;
    assign sb.err_spurious_wb = err_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
//------------------------------------------------------------------------------
// tb_issue_scoreboard : directed vectors with a queue-based checking monitor
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    typedef struct packed {
        logic        stall;
        logic        fire;
        logic [31:0] busy;
        logic [3:0]  infl;
        logic        err;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_bad;
    int   vec_id;
    exp_t exp_q[$];
    int   id_q[$];

    issue_scoreboard_if sb_if ();

    issue_scoreboard #(.MAX_INFLIGHT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sb   (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are combinational, so every half-cycle after a drive is a valid sample.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = '{stall: sb_if.stall, fire: sb_if.issue_fire, busy: sb_if.busy_vec,
                   infl: sb_if.inflight, err: sb_if.err_spurious_wb};
            n_vec = n_vec + 1;
            if (a !== e) begin
                n_bad = n_bad + 1;
                $display("FAIL vec%0d: got stall=%0b fire=%0b busy=%08h infl=%0d err=%0b, need stall=%0b fire=%0b busy=%08h infl=%0d err=%0b",
                         id, a.stall, a.fire, a.busy, a.infl, a.err,
                         e.stall, e.fire, e.busy, e.infl, e.err);
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic lg, input logic md,
                         input logic fl, input logic wv, input logic [4:0] wr,
                         input logic dn, input logic rs);
        sb_if.issue_valid  = v;
        sb_if.issue_rs1    = r1;
        sb_if.issue_rs2    = r2;
        sb_if.issue_rd     = rd;
        sb_if.issue_long   = lg;
        sb_if.issue_muldiv = md;
        sb_if.flush        = fl;
        sb_if.wb_valid     = wv;
        sb_if.wb_rd        = wr;
        sb_if.muldiv_done  = dn;
        rstn               = rs;
    endtask

    task automatic vec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic lg, input logic md,
                       input logic fl, input logic wv, input logic [4:0] wr,
                       input logic dn, input logic rs,
                       input logic es, input logic ef, input logic [31:0] eb,
                       input logic [3:0] ei, input logic ee);
        @(posedge clk);
        #1;
        drive(v, r1, r2, rd, lg, md, fl, wv, wr, dn, rs);
        vec_id = vec_id + 1;
        exp_q.push_back('{stall: es, fire: ef, busy: eb, infl: ei, err: ee});
        id_q.push_back(vec_id);
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        vec_id = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        //   v  r1 r2 rd lg md fl wv wr dn rs | stall fire busy        infl err
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0000, 0, 0);
        // load x5, then dependent add x6,x5,x1
        vec(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 0);
        vec(1, 5, 1, 6, 0, 0, 0, 0, 0, 0, 1,  1, 0, 32'h0000_0020, 1, 0);
        vec(1, 5, 1, 6, 0, 0, 0, 0, 0, 0, 1,  1, 0, 32'h0000_0020, 1, 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        vec(1, 5, 1, 6, 0, 0, 0, 1, 5, 0, 1,  0, 1, 32'h0000_0020, 1, 0);
`else
        vec(1, 5, 1, 6, 0, 0, 0, 1, 5, 0, 1,  1, 0, 32'h0000_0020, 1, 0);
`endif
        vec(1, 5, 1, 6, 0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 0);
        // fill the inflight table with loads to x1..x4
        vec(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 0);
        vec(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0002, 1, 0);
        vec(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0006, 2, 0);
        vec(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_000E, 3, 0);
        vec(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1,  1, 0, 32'h0000_001E, 4, 0);
        vec(1, 9,10, 8, 0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_001E, 4, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1,  0, 0, 32'h0000_001E, 4, 0);
        // set x9 and clear x2 in the same cycle: inflight holds
        vec(1, 0, 0, 9, 1, 0, 0, 1, 2, 0, 1,  0, 1, 32'h0000_001C, 3, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1,  0, 0, 32'h0000_0218, 3, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1,  0, 0, 32'h0000_0210, 2, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1,  0, 0, 32'h0000_0200, 1, 0);
        // mul x3 then div x4: blocked until muldiv_done has been registered
        vec(1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 0);
        vec(1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 1,  1, 0, 32'h0000_0008, 1, 0);
        vec(1, 0, 0, 4, 1, 1, 0, 1, 3, 0, 1,  1, 0, 32'h0000_0008, 1, 0);
        vec(1, 0, 0, 4, 1, 1, 0, 0, 0, 1, 1,  1, 0, 32'h0000_0000, 0, 0);
        vec(1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 1,  0, 0, 32'h0000_0010, 1, 0);
        // done pulse coinciding with a new mul issue: unit must stay busy
        vec(1, 0, 0, 5, 1, 1, 0, 0, 0, 1, 1,  0, 1, 32'h0000_0000, 0, 0);
        vec(1, 0, 0, 6, 1, 1, 0, 0, 0, 0, 1,  1, 0, 32'h0000_0020, 1, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 1,  0, 0, 32'h0000_0020, 1, 0);
        // spurious writebacks to x9 (idle) and x0
        vec(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1,  0, 0, 32'h0000_0000, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0, 0, 32'h0000_0000, 0, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 32'h0000_0000, 0, 1);
        // build busy=0x30/inflight=2, then flush with and without a hazard
        vec(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 1);
        vec(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0020, 1, 1);
        vec(1, 0, 0, 7, 1, 0, 1, 0, 0, 0, 1,  0, 0, 32'h0000_0030, 2, 1);
        vec(1, 5, 0, 8, 0, 0, 1, 0, 0, 0, 1,  1, 0, 32'h0000_0030, 2, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 32'h0000_0030, 2, 1);
        // reset mid-operation, then a stale writeback to x5
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0030, 2, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1,  0, 0, 32'h0000_0000, 0, 0);
        vec(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1,  0, 1, 32'h0000_0000, 0, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 32'h0000_0010, 1, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d checks left unread, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
